// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side stream of the receive FIFO head: valid/data/parity flag with ready.
interface uart_rx_ctrl_if;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_ready;

  modport master (output m_valid, m_data, m_perr, input m_ready);
  modport slave  (input m_valid, m_data, m_perr, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive controller: captures uart_rx frames into a FWFT FIFO, paces the sender via
// rts_n hysteresis, and keeps sticky overrun plus saturating parity-error statistics.
module uart_rx_ctrl #(
  parameter  int DEPTH  = 16,
  parameter  int RTS_HI = 12,
  parameter  int RTS_LO = 4,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_done,
  input  logic [7:0]           rx_data,
  input  logic                 parity_error,
  input  logic [1:0]           data_bit_num,
  output logic                 rts_n,
  uart_rx_ctrl_if.master       m_if,
  output logic [CW-1:0]        fifo_count,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic [7:0]           perr_count,
  input  logic                 perr_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(RTS_HI);
  localparam logic [CW-1:0] LO_C    = CW'(RTS_LO);

  typedef enum logic [1:0] {ST_INIT, ST_OPEN, ST_HOLD} state_t;

  logic          r_done_d;
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_overrun;
  logic [7:0]    r_perr_cnt;
  logic          r_rts_n;
  state_t        r_state;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_accept;
  logic          w_drop;
  logic [7:0]    w_mask;
  logic [CW-1:0] w_cnt_n;
  state_t        w_state_n;

  assign w_push   = rx_done & ~r_done_d;
  assign w_pop    = m_if.m_valid & m_if.m_ready;
  assign w_full   = (r_cnt == DEPTH_C);
  // A full FIFO still takes a frame when the head leaves in the same cycle.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  always_comb begin
    w_mask = 8'hFF;
    case (data_bit_num)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end

  always_comb begin
    w_cnt_n = r_cnt;
    case ({w_accept, w_pop})
      2'b10:   w_cnt_n = r_cnt + CW'(1);
      2'b01:   w_cnt_n = r_cnt - CW'(1);
      default: w_cnt_n = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_d <= 1'b1;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= '0;
    end else begin
      r_done_d <= rx_done;
      r_cnt    <= w_cnt_n;
      if (w_accept) begin
        r_mem[r_wr] <= {parity_error, rx_data & w_mask};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun  <= 1'b0;
      r_perr_cnt <= '0;
    end else begin
      if (w_drop)           r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;

      // Dropped frames still count; a clear in the same cycle as an error restarts at 1.
      if (w_push && parity_error) begin
        if (perr_clr)                r_perr_cnt <= 8'd1;
        else if (r_perr_cnt != '1)   r_perr_cnt <= r_perr_cnt + 8'd1;
      end else if (perr_clr) begin
        r_perr_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_INIT: w_state_n = ST_OPEN;
      ST_OPEN: if (w_cnt_n >= HI_C) w_state_n = ST_HOLD;
      ST_HOLD: if (w_cnt_n <= LO_C) w_state_n = ST_OPEN;
      default: w_state_n = ST_INIT;
    endcase
  end

  // rts_n decodes the next state so it flips together with fifo_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_rts_n <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_rts_n <= (w_state_n != ST_OPEN);
    end
  end

  assign m_if.m_valid = (r_cnt != '0);
  assign m_if.m_data  = r_mem[r_rd][7:0];
  assign m_if.m_perr  = r_mem[r_rd][8];
  assign rts_n        = r_rts_n;
  assign fifo_count   = r_cnt;
  assign overrun      = r_overrun;
  assign perr_count   = r_perr_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_ctrl;

  localparam int DEPTH  = 16;
  localparam int RTS_HI = 12;
  localparam int RTS_LO = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          parity_error;
  logic [1:0]    data_bit_num;
  logic          rts_n;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic          overrun_clr;
  logic [7:0]    perr_count;
  logic          perr_clr;

  uart_rx_ctrl_if u_if ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .data_bit_num (data_bit_num),
    .rts_n        (rts_n),
    .m_if         (u_if.master),
    .fifo_count   (fifo_count),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .perr_count   (perr_count),
    .perr_clr     (perr_clr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [8:0] mq[$];
  bit         m_ovr;
  int         m_perr;
  bit         m_init;
  bit         m_hold;
  bit         m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 0;
    m_perr = 0;
    m_init = 1;
    m_hold = 0;
    m_prev = 1;
  endtask

  task automatic model_update();
    bit push, pop, drop;
    int mk;
    logic [7:0] md;
    push   = rx_done && !m_prev;
    m_prev = rx_done;
    pop    = (mq.size() != 0) && u_if.m_ready;
    drop   = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mk = (1 << (5 + int'(data_bit_num))) - 1;
      md = rx_data & 8'(mk);
      if (mq.size() < DEPTH) mq.push_back({parity_error, md});
      else drop = 1;
      if (parity_error) m_perr = perr_clr ? 1 : ((m_perr >= 255) ? 255 : m_perr + 1);
      else if (perr_clr) m_perr = 0;
    end else if (perr_clr) begin
      m_perr = 0;
    end
    if (drop) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (m_init) begin
      m_init = 0;
      m_hold = 0;
    end else if (!m_hold && mq.size() >= RTS_HI) begin
      m_hold = 1;
    end else if (m_hold && mq.size() <= RTS_LO) begin
      m_hold = 0;
    end
  endtask

  task automatic compare();
    check("valid", u_if.m_valid, (mq.size() != 0));
    check("count", fifo_count, mq.size());
    check("rts_n", rts_n, (m_init || m_hold));
    check("overrun", overrun, m_ovr);
    check("perr_count", perr_count, m_perr);
    if (mq.size() != 0) begin
      check("head_data", u_if.m_data, mq[0][7:0]);
      check("head_perr", u_if.m_perr, mq[0][8]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] bits, input logic pe, input int hold);
    rx_data      = d;
    data_bit_num = bits;
    parity_error = pe;
    rx_done      = 1'b1;
    repeat (hold) step();
    rx_done      = 1'b0;
    step();
  endtask

  task automatic pop_one();
    u_if.m_ready = 1'b1;
    step();
    u_if.m_ready = 1'b0;
  endtask

  task automatic drain();
    u_if.m_ready = 1'b1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) step();
    u_if.m_ready = 1'b0;
    step();
    check("drain_empty", fifo_count, 0);
  endtask

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = '0; parity_error = 1'b0; data_bit_num = 2'b11;
    overrun_clr = 1'b0; perr_clr = 1'b0; u_if.m_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mdata", u_if.m_data, 8'h00);
    check("rst_mperr", u_if.m_perr, 1'b0);
    check("rst_rts", rts_n, 1'b1);
    rst = 1'b0;
    compare();
    step();
    check("rts_open", rts_n, 1'b0);

    // one push per rx_done level
    rx_data = 8'hA5; data_bit_num = 2'b11; parity_error = 1'b0; rx_done = 1'b1;
    step();
    check("a5_cnt1", fifo_count, 1);
    check("a5_data", u_if.m_data, 8'hA5);
    repeat (4) step();
    rx_done = 1'b0;
    step();
    check("a5_single", fifo_count, 1);
    drain();

    send_frame(8'hFB, 2'b00, 1'b0, 1);
    check("mask5", u_if.m_data, 8'h1B);
    pop_one();
    send_frame(8'hEA, 2'b01, 1'b0, 1);
    check("mask6", u_if.m_data, 8'h2A);
    pop_one();

    u_if.m_ready = 1'b1;
    repeat (3) send_frame(8'($urandom), 2'b11, 1'b1, 1);
    check("perr3", perr_count, 3);
    rx_data = 8'h55; parity_error = 1'b1; rx_done = 1'b1; perr_clr = 1'b1;
    step();
    perr_clr = 1'b0;
    check("perr_clr_inc", perr_count, 1);
    rx_done = 1'b0;
    step();
    repeat (300) send_frame(8'($urandom), 2'($urandom), 1'b1, 1);
    check("perr_sat", perr_count, 255);
    perr_clr = 1'b1;
    step();
    perr_clr = 1'b0;
    check("perr_clr", perr_count, 0);
    drain();

    // rts hysteresis
    repeat (12) send_frame(8'($urandom), 2'b11, 1'b0, 1);
    check("rts_hi_cnt", fifo_count, 12);
    check("rts_hi", rts_n, 1'b1);
    for (int i = 0; i < 7 && fifo_count > 5; i++) pop_one();
    check("rts_5_cnt", fifo_count, 5);
    check("rts_5", rts_n, 1'b1);
    pop_one();
    check("rts_4_cnt", fifo_count, 4);
    check("rts_4", rts_n, 1'b0);

    // overrun and full push+pop across pointer wrap
    repeat (12) send_frame(8'($urandom), 2'b11, 1'($urandom), 1);
    check("full_cnt", fifo_count, 16);
    check("full_no_ovr", overrun, 1'b0);
    send_frame(8'h77, 2'b11, 1'b0, 1);
    check("drop_ovr", overrun, 1'b1);
    check("drop_cnt", fifo_count, 16);
    rx_data = 8'h3C; data_bit_num = 2'b11; parity_error = 1'b0; rx_done = 1'b1; u_if.m_ready = 1'b1;
    step();
    u_if.m_ready = 1'b0; rx_done = 1'b0;
    check("pushpop_cnt", fifo_count, 16);
    step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    rx_data = 8'h11; rx_done = 1'b1; overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0; rx_done = 1'b0;
    check("ovr_set_prio", overrun, 1'b1);
    step();
    drain();

    // reset mid-operation with rx_done held through release
    repeat (7) send_frame(8'($urandom), 2'b11, 1'b0, 1);
    check("pre_rst_cnt", fifo_count, 7);
    rx_done = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst_cnt", fifo_count, 0);
    check("arst_valid", u_if.m_valid, 1'b0);
    check("arst_rts", rts_n, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();
    step();
    check("rel_cnt", fifo_count, 0);
    check("rel_rts", rts_n, 1'b0);
    rx_done = 1'b0;
    step();

    // random traffic
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 2 == 0) ? 15 : 70;
      for (int c = 0; c < 500; c++) begin
        if (rx_done) begin
          if ($urandom_range(2) == 0) rx_done = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          rx_done      = 1'b1;
          rx_data      = 8'($urandom);
          data_bit_num = 2'($urandom);
          parity_error = ($urandom_range(3) == 0);
        end
        u_if.m_ready = ($urandom_range(99) < rdy_pct);
        overrun_clr  = ($urandom_range(31) == 0);
        perr_clr     = ($urandom_range(63) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller sitting between `uart_rx` and the bus/host side. It captures each completed frame from `uart_rx`, masks the data to the configured width, and buffers it with its parity flag in a first-word-fall-through FIFO. It paces the remote transmitter by driving `rts_n` with hysteresis on FIFO occupancy, and keeps sticky overrun and saturating parity-error statistics.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `RTS_HI`, 12: occupancy at or above which `rts_n` deasserts; `RTS_LO` < `RTS_HI` ≤ `DEPTH`.
- `RTS_LO`, 4: occupancy at or below which `rts_n` reasserts.
- `CW` (localparam) = $clog2(DEPTH+1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_done`  in  1  from `uart_rx`; level, high for ≥1 cycle per frame.
- `rx_data`  in  8  from `uart_rx`; valid while `rx_done`=1.
- `parity_error`  in  1  from `uart_rx`; valid while `rx_done`=1.
- `data_bit_num`  in  2  active frame width: 00=5, 01=6, 10=7, 11=8 bits.
- `rts_n`  out  1  to `uart_rx` and pin; 0 = ready to receive.
- `m_valid`  out  1  FIFO head valid.
- `m_data`  out  8  head data, masked.
- `m_perr`  out  1  head parity-error flag.
- `m_ready`  in  1  consumer accepts head when `m_valid`&`m_ready`.
- `fifo_count`  out  CW  current occupancy, 0..DEPTH.
- `overrun`  out  1  sticky: frame dropped because FIFO was full.
- `overrun_clr`  in  1  clears `overrun`.
- `perr_count`  out  8  saturating count of frames with parity error.
- `perr_clr`  in  1  clears `perr_count`.

## Operation
- Frame capture: register `done_d` <= `rx_done`; `push` = `rx_done` & ~`done_d`, one push per high level regardless of its length.
- Masking at push: data & {0x1F, 0x3F, 0x7F, 0xFF} by `data_bit_num` sampled in the push cycle; the entry is {`parity_error`, masked data}, 9 bits.
- FIFO: register array, wr/rd pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a separate CW-bit count. `pop` = `m_valid` & `m_ready`. `m_valid` = (count≠0); `m_data`/`m_perr` driven from the entry at rd pointer.
- Full (count=DEPTH), push without pop: entry dropped, pointers and count unchanged, `overrun` set.
- Full, push with pop in the same cycle: both are accepted, count stays DEPTH, no overrun.
- Empty, push: `m_valid` rises the next cycle. Pop while empty cannot occur because `m_valid`=0.
- `overrun`: set on drop; cleared by `overrun_clr`; set has priority when both occur in the same cycle.
- `perr_count`: +1 on each push with `parity_error`=1, dropped frames included; saturates at 255. `perr_clr` with a simultaneous increment gives 1; `perr_clr` alone gives 0.
- Flow-control FSM, registered, evaluated on next-cycle count `cnt_n`:
  - INIT: `rts_n`=1; always goes to OPEN.
  - OPEN: `rts_n`=0; goes to HOLD when `cnt_n` ≥ RTS_HI.
  - HOLD: `rts_n`=1; goes to OPEN when `cnt_n` ≤ RTS_LO.
  - `rts_n` is a registered decode of the state, so it changes in the same cycle `fifo_count` crosses the threshold.
- Frames arriving while `rts_n`=1 are still accepted if space remains; `rts_n` is advisory only.

## Timing
- Reset values: `rts_n`=1 (state INIT), `m_valid`=0, `m_data`=0x00 (array cleared), `m_perr`=0, `fifo_count`=0, `overrun`=0, `perr_count`=0, `done_d`=1.
- `done_d` resets to 1 so that an `rx_done` held high across reset release causes no spurious push.
- First cycle after reset release: state INIT; `rts_n` goes to 0 one cycle later.
- Push latency: `rx_done` rises in cycle N → entry written at the end of N → `m_valid`, `m_data`, and `fifo_count`+1 visible in N+1.
- Pop: head consumed at the end of the cycle with `m_valid`&`m_ready`; the next entry, or `m_valid`=0, appears in the next cycle with no bubble.
- Reset asserted mid-operation: immediately empties the FIFO and restores all reset values; in-flight data is lost.

## Test plan
- 8N1 0xA5 with `rx_done` held high 5 cycles → exactly one entry; `m_data`=0xA5, `m_perr`=0; `fifo_count`=1 one cycle after the rising edge.
- `data_bit_num`=00 with `rx_data`=0xFB → `m_data`=0x1B; `data_bit_num`=01 with 0xEA → 0x2A.
- `parity_error`=1 on 3 frames, then `perr_clr` coincident with a 4th error frame → `perr_count` 3 → 1. Inject 300 error frames → `perr_count` holds at 255.
- `m_ready`=0, push 12 frames → `rts_n`=1 in the cycle `fifo_count`=12. Pop down to 5 → still 1. Pop to 4 → `rts_n`=0.
- Fill 16 entries, push a 17th → dropped, `overrun`=1, `fifo_count`=16. Push with pop in the same cycle → accepted, count=16, data order preserved across pointer wrap. `overrun_clr` coincident with a new drop → `overrun` stays 1.
- Assert `rst` with 7 entries queued and `rx_done` high, release with `rx_done` still high → `fifo_count`=0, `m_valid`=0, no push, `rts_n`=1 then 0 after one cycle.
